auth_tx_blk: RTL and testbench



---
 rtl/auth_pkg.sv | 15 +
 rtl/auth_tx_blk_uart_tx.sv | 80 ++++++++
 rtl/auth_tx_blk.sv | 101 ++++++++++
 tb/tb_auth_tx_blk.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// Shared constants and sequencer state type for the rider-authentication UART link.
// The command bytes are also used by the receiving end.
`timescale 1ns/1ps
package auth_pkg;

    localparam logic [7:0] AUTH_GO   = 8'h67;
    localparam logic [7:0] AUTH_STOP = 8'h73;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } seq_state_t;

endpackage

// File: rtl/auth_tx_blk_uart_tx.sv
// 8N1 UART transmitter: the start bit, eight data bits LSB first and the stop bit.
// tx_done marks the final clock of the stop bit.
`timescale 1ns/1ps
module UART_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       tx_busy
);

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'd9;

    tx_state_t   state_q, state_d;
    logic [9:0]  shift_q, shift_d;
    logic [11:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic        bit_end;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        bit_end = (state_q == TX_SHIFT) && (baud_q == BAUD_LAST);
        tx_done = bit_end && (bit_q == BIT_LAST);
        case (state_q)
            TX_IDLE: begin
                if (trmt) begin
                    shift_d = {1'b1, tx_data, 1'b0};
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_SHIFT;
                end
            end
            default: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = TX_IDLE;
                    end else begin
                        shift_d = {1'b1, shift_q[9:1]};
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 12'd1;
                end
            end
        endcase
    end

    // Line level is decoded from state so reset forces it high without waiting for a clock.
    assign TX      = (state_q == TX_SHIFT) ? shift_q[0] : 1'b1;
    assign tx_busy = (state_q == TX_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            shift_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: rtl/auth_tx_blk.sv
// Authentication command transmitter: queues go/stop requests and sends them as
// 'g'/'s' UART frames, tracking whether the last completed command armed the rider.
`timescale 1ns/1ps
module auth_tx_blk
    import auth_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go_req,
    input  logic stop_req,
    output logic TX,
    output logic tx_busy,
    output logic cmd_done,
    output logic armed
);

    seq_state_t state_q, state_d;
    logic       go_pend_q, go_pend_d;
    logic       stop_pend_q, stop_pend_d;
    logic [7:0] byte_q, byte_d;
    logic       armed_q, armed_d;
    logic       go_clr, stop_clr;
    logic       trmt;
    logic       tx_done;

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        armed_d  = armed_q;
        go_clr   = 1'b0;
        stop_clr = 1'b0;
        trmt     = 1'b0;
        case (state_q)
            IDLE: begin
                // Stop outranks go; a coincident go simply stays pending.
                if (stop_pend_q) begin
                    byte_d  = AUTH_STOP;
                    state_d = LOAD;
                end else if (go_pend_q) begin
                    byte_d  = AUTH_GO;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                trmt     = 1'b1;
                stop_clr = (byte_q == AUTH_STOP);
                go_clr   = (byte_q == AUTH_GO);
                state_d  = WAIT;
            end
            default: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (tx_done) begin
            if (byte_q == AUTH_GO) begin
                armed_d = 1'b1;
            end else if (byte_q == AUTH_STOP) begin
                armed_d = 1'b0;
            end
        end
        // A request landing on its own clear cycle re-arms the flag.
        go_pend_d   = (go_pend_q & ~go_clr) | go_req;
        stop_pend_d = (stop_pend_q & ~stop_clr) | stop_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            go_pend_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            byte_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            go_pend_q   <= go_pend_d;
            stop_pend_q <= stop_pend_d;
            byte_q      <= byte_d;
            armed_q     <= armed_d;
        end
    end

    UART_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .trmt   (trmt),
        .tx_data(byte_q),
        .TX     (TX),
        .tx_done(tx_done),
        .tx_busy(tx_busy)
    );

    assign cmd_done = tx_done;
    assign armed    = armed_q;

endmodule

// File: tb/tb_auth_tx_blk.sv
// Directed bench for auth_tx_blk at 16 clocks/bit: frame shape, timing, priority,
// merging, set/clear race and asynchronous reset.
`timescale 1ns/1ps
module tb_auth_tx_blk;

    localparam int BD = 16;
    localparam logic [7:0] GO_B   = 8'h67;
    localparam logic [7:0] STOP_B = 8'h73;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic go_req   = 1'b0;
    logic stop_req = 1'b0;
    wire  TX, tx_busy, cmd_done, armed;

    int vecs       = 0;
    int miss       = 0;
    int done_total = 0;

    auth_tx_blk #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go_req  (go_req),
        .stop_req(stop_req),
        .TX      (TX),
        .tx_busy (tx_busy),
        .cmd_done(cmd_done),
        .armed   (armed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_done === 1'b1) done_total++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // One-cycle request pulse; returns just after the edge that samples it.
    task automatic pulse(input logic g, input logic s);
        @(posedge clk); #1;
        go_req   = g;
        stop_req = s;
        @(posedge clk); #1;
        go_req   = 1'b0;
        stop_req = 1'b0;
    endtask

    // Waits for a start bit, then checks every clock of the frame against the 8N1
    // pattern, decodes the byte at mid-bit and checks armed one clock after the frame.
    task automatic expect_frame(input string tag, input logic [7:0] exp,
                                input int exp_lat, input logic exp_armed);
        int lat = 0;
        int bad = 0;
        int busy_bad = 0;
        int done_n = 0;
        int done_at = 0;
        logic [9:0] fr;
        logic [9:0] rx;
        fr = {1'b1, exp, 1'b0};
        rx = '0;
        do begin
            @(negedge clk);
            lat++;
        end while (TX !== 1'b0 && lat < 400);
        chk({tag, "_start_lat"}, lat, exp_lat);
        if (TX !== 1'b0) return;
        for (int c = 1; c <= 10 * BD; c++) begin
            if (c > 1) @(negedge clk);
            if (TX !== fr[(c - 1) / BD]) bad++;
            if (tx_busy !== 1'b1) busy_bad++;
            if (cmd_done === 1'b1) begin
                done_n++;
                done_at = c;
            end
            if ((c - 1) % BD == BD / 2) rx[(c - 1) / BD] = TX;
        end
        @(negedge clk);
        chk({tag, "_bit_errs"}, bad, 0);
        chk({tag, "_busy_errs"}, busy_bad, 0);
        chk({tag, "_done_cnt"}, done_n, 1);
        chk({tag, "_done_clk"}, done_at, 10 * BD);
        chk({tag, "_rx_byte"}, rx[8:1], exp);
        chk({tag, "_idle_after"}, {tx_busy, TX}, 2'b01);
        chk({tag, "_armed"}, armed, exp_armed);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        chk(tag, lows, 0);
    endtask

    initial begin
        int d0;
        #2;
        chk("rst_outputs", {TX, tx_busy, cmd_done, armed}, 4'b1000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("rst_quiet", 40);

        pulse(1'b1, 1'b0);
        expect_frame("go", GO_B, 3, 1'b1);

        pulse(1'b1, 1'b1);
        expect_frame("sim_s", STOP_B, 3, 1'b0);
        expect_frame("sim_g", GO_B, 2, 1'b1);
        expect_quiet("sim_quiet", 60);

        pulse(1'b0, 1'b1);
        fork
            expect_frame("mrg_s", STOP_B, 3, 1'b0);
            begin
                repeat (20) @(posedge clk);
                pulse(1'b1, 1'b0);
                repeat (40) @(posedge clk);
                pulse(1'b1, 1'b0);
                repeat (40) @(posedge clk);
                pulse(1'b1, 1'b0);
            end
        join
        expect_frame("mrg_g", GO_B, 2, 1'b1);
        expect_quiet("mrg_quiet", 300);

        pulse(1'b0, 1'b1);
        fork
            expect_frame("race_s1", STOP_B, 3, 1'b0);
            begin
                @(posedge clk); #1;
                stop_req = 1'b1;
                @(posedge clk); #1;
                stop_req = 1'b0;
            end
        join
        expect_frame("race_s2", STOP_B, 2, 1'b0);
        expect_quiet("race_quiet", 300);

        d0 = done_total;
        pulse(1'b1, 1'b0);
        expect_frame("lb_g1", GO_B, 3, 1'b1);
        pulse(1'b0, 1'b1);
        expect_frame("lb_s", STOP_B, 3, 1'b0);
        pulse(1'b1, 1'b0);
        expect_frame("lb_g2", GO_B, 3, 1'b1);
        chk("lb_done_pulses", done_total - d0, 3);

        pulse(1'b1, 1'b0);
        repeat (40) @(negedge clk);
        pulse(1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("pre_rst_state", {TX, tx_busy, armed}, {TX, 2'b11});
        rst_n = 1'b0;
        #1;
        chk("midframe_rst", {TX, tx_busy, cmd_done, armed}, 4'b1000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("post_rst_quiet", 300);
        chk("post_rst_armed", armed, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
